// File: rtl/rv_pkg.sv
// Shared RV32I/RV64I decode definitions: major opcodes, immediate formats
// and the immediate sign-extension helper.
package rv_pkg;

    localparam logic [6:0] OpLoad    = 7'h03;
    localparam logic [6:0] OpOpImm   = 7'h13;
    localparam logic [6:0] OpAuipc   = 7'h17;
    localparam logic [6:0] OpOpImm32 = 7'h1B;
    localparam logic [6:0] OpStore   = 7'h23;
    localparam logic [6:0] OpOp      = 7'h33;
    localparam logic [6:0] OpLui     = 7'h37;
    localparam logic [6:0] OpOp32    = 7'h3B;
    localparam logic [6:0] OpBranch  = 7'h63;
    localparam logic [6:0] OpJalr    = 7'h67;
    localparam logic [6:0] OpJal     = 7'h6F;

    typedef enum logic [2:0] {ImmI, ImmS, ImmB, ImmU, ImmJ, ImmNone} imm_fmt_e;

    // Full 64-bit sign-extended immediate; callers truncate to XLEN.
    function automatic logic [63:0] imm_ext(input logic [31:0] instr, input imm_fmt_e fmt);
        case (fmt)
            ImmI:    return {{52{instr[31]}}, instr[31:20]};
            ImmS:    return {{52{instr[31]}}, instr[31:25], instr[11:7]};
            ImmB:    return {{51{instr[31]}}, instr[31], instr[7], instr[30:25],
                             instr[11:8], 1'b0};
            ImmU:    return {{32{instr[31]}}, instr[31:12], 12'b0};
            ImmJ:    return {{43{instr[31]}}, instr[31], instr[19:12], instr[20],
                             instr[30:21], 1'b0};
            default: return 64'b0;
        endcase
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard for in-flight destination registers, with writeback
// clear bypassed onto the two hazard read ports.
module reg_scoreboard
    import rv_pkg::*;
#(
    parameter int unsigned NREGS     = 32,
    parameter bit          SB_ENABLE = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_en,
    input  logic [4:0] set_idx,
    input  logic       clr_en,
    input  logic [4:0] clr_idx,
    input  logic       kill_en,
    input  logic [4:0] kill_idx,
    input  logic [4:0] rd_idx_a,
    input  logic [4:0] rd_idx_b,
    output logic       rd_busy_a,
    output logic       rd_busy_b
);

    localparam logic [NREGS-1:0] Bit0 = NREGS'(1);

    logic [NREGS-1:0] busy_q, busy_d;
    logic [NREGS-1:0] set_mask, clr_mask, kill_mask, busy_eff;
    logic [31:0]      busy_ext;

    always_comb begin
        // Indices >= NREGS shift out of range and produce an empty mask.
        set_mask  = set_en  ? NREGS'(32'd1 << set_idx)  : '0;
        clr_mask  = clr_en  ? NREGS'(32'd1 << clr_idx)  : '0;
        kill_mask = kill_en ? NREGS'(32'd1 << kill_idx) : '0;

        busy_eff = busy_q & ~clr_mask;
        busy_ext = 32'(busy_eff);
        rd_busy_a = SB_ENABLE ? busy_ext[rd_idx_a] : 1'b0;
        rd_busy_b = SB_ENABLE ? busy_ext[rd_idx_b] : 1'b0;

        // Set is applied last so it wins over a same-cycle clear.
        busy_d = ((busy_q & ~clr_mask & ~kill_mask) | set_mask) & ~Bit0;
        if (!SB_ENABLE) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/decode_unit.sv
// Registered RV32I/RV64I decode stage with valid/ready handshake and an
// integrated RAW scoreboard that stalls fetch on in-flight destinations.
module decode_unit
    import rv_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NREGS     = 32,
    parameter bit          SB_ENABLE = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic            out_use_rs1,
    output logic            out_use_rs2,
    output logic            out_we_rd,
    output logic            out_illegal,
    input  logic            flush,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd
);

    logic [6:0]      opcode;
    logic [4:0]      rs1_f, rs2_f, rd_f;
    imm_fmt_e        fmt;
    logic            raw_rs1, raw_rs2, raw_rd, bad_op, illegal;
    logic            dec_use_rs1, dec_use_rs2, dec_we_rd;
    logic [4:0]      dec_rs1, dec_rs2, dec_rd;
    logic [XLEN-1:0] dec_imm;
    logic            busy_a, busy_b, hazard, accept;

    assign opcode = in_instr[6:0];
    assign rs1_f  = in_instr[19:15];
    assign rs2_f  = in_instr[24:20];
    assign rd_f   = in_instr[11:7];

    always_comb begin
        fmt     = ImmNone;
        raw_rs1 = 1'b0;
        raw_rs2 = 1'b0;
        raw_rd  = 1'b0;
        bad_op  = 1'b0;
        case (opcode)
            OpLui, OpAuipc: begin fmt = ImmU; raw_rd = 1'b1; end
            OpJal:          begin fmt = ImmJ; raw_rd = 1'b1; end
            OpJalr, OpLoad, OpOpImm: begin
                fmt = ImmI; raw_rd = 1'b1; raw_rs1 = 1'b1;
            end
            OpBranch: begin fmt = ImmB; raw_rs1 = 1'b1; raw_rs2 = 1'b1; end
            OpStore:  begin fmt = ImmS; raw_rs1 = 1'b1; raw_rs2 = 1'b1; end
            OpOp:     begin raw_rd = 1'b1; raw_rs1 = 1'b1; raw_rs2 = 1'b1; end
            OpOpImm32: begin
                fmt = ImmI; raw_rd = 1'b1; raw_rs1 = 1'b1; bad_op = (XLEN == 32);
            end
            OpOp32: begin
                raw_rd = 1'b1; raw_rs1 = 1'b1; raw_rs2 = 1'b1; bad_op = (XLEN == 32);
            end
            default: bad_op = 1'b1;
        endcase

        illegal = bad_op || (in_instr[1:0] != 2'b11)
               || (raw_rs1 && (32'(rs1_f) >= NREGS))
               || (raw_rs2 && (32'(rs2_f) >= NREGS))
               || (raw_rd  && (32'(rd_f)  >= NREGS));

        // Illegal instructions flow downstream inert: no operands, no writeback.
        dec_use_rs1 = raw_rs1 & ~illegal;
        dec_use_rs2 = raw_rs2 & ~illegal;
        dec_we_rd   = raw_rd & ~illegal & (rd_f != 5'd0);
        dec_rs1     = dec_use_rs1 ? rs1_f : 5'd0;
        dec_rs2     = dec_use_rs2 ? rs2_f : 5'd0;
        dec_rd      = dec_we_rd ? rd_f : 5'd0;
        dec_imm     = XLEN'(imm_ext(in_instr, fmt));
    end

    assign hazard   = in_valid & ((dec_use_rs1 & busy_a) | (dec_use_rs2 & busy_b));
    assign in_ready = ~flush & ~hazard & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;

    reg_scoreboard #(
        .NREGS     (NREGS),
        .SB_ENABLE (SB_ENABLE)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .set_en    (accept & dec_we_rd),
        .set_idx   (dec_rd),
        .clr_en    (wb_valid),
        .clr_idx   (wb_rd),
        .kill_en   (flush & out_valid & out_we_rd),
        .kill_idx  (out_rd),
        .rd_idx_a  (dec_rs1),
        .rd_idx_b  (dec_rs2),
        .rd_busy_a (busy_a),
        .rd_busy_b (busy_b)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_rs1     <= '0;
            out_rs2     <= '0;
            out_rd      <= '0;
            out_imm     <= '0;
            out_opcode  <= '0;
            out_funct3  <= '0;
            out_funct7  <= '0;
            out_use_rs1 <= 1'b0;
            out_use_rs2 <= 1'b0;
            out_we_rd   <= 1'b0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_pc      <= in_pc;
            out_rs1     <= dec_rs1;
            out_rs2     <= dec_rs2;
            out_rd      <= dec_rd;
            out_imm     <= dec_imm;
            out_opcode  <= opcode;
            out_funct3  <= in_instr[14:12];
            out_funct7  <= in_instr[31:25];
            out_use_rs1 <= dec_use_rs1;
            out_use_rs2 <= dec_use_rs2;
            out_we_rd   <= dec_we_rd;
            out_illegal <= illegal;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_unit.sv
// Directed bench for decode_unit: three instances (RV32, RV64, RV32E) share
// stimulus; expected values are hand-computed per vector.
module tb_decode_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, out_ready, flush, wb_valid;
    logic [31:0] in_instr, in_pc;
    logic [4:0]  wb_rd;

    // RV32 instance
    logic        in_ready, out_valid, out_use_rs1, out_use_rs2, out_we_rd, out_illegal;
    logic [31:0] out_pc, out_imm;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [6:0]  out_opcode, out_funct7;
    logic [2:0]  out_funct3;

    // RV64 instance
    logic        r64_in_ready, r64_valid, r64_use_rs1, r64_use_rs2, r64_we_rd, r64_illegal;
    logic [63:0] r64_pc, r64_imm;
    logic [4:0]  r64_rs1, r64_rs2, r64_rd;
    logic [6:0]  r64_opcode, r64_funct7;
    logic [2:0]  r64_funct3;

    // RV32E instance
    logic        r16_in_ready, r16_valid, r16_use_rs1, r16_use_rs2, r16_we_rd, r16_illegal;
    logic [31:0] r16_pc, r16_imm;
    logic [4:0]  r16_rs1, r16_rs2, r16_rd;
    logic [6:0]  r16_opcode, r16_funct7;
    logic [2:0]  r16_funct3;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    decode_unit #(.XLEN(32), .NREGS(32), .SB_ENABLE(1'b1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_imm(out_imm), .out_opcode(out_opcode), .out_funct3(out_funct3),
        .out_funct7(out_funct7), .out_use_rs1(out_use_rs1), .out_use_rs2(out_use_rs2),
        .out_we_rd(out_we_rd), .out_illegal(out_illegal), .flush(flush),
        .wb_valid(wb_valid), .wb_rd(wb_rd)
    );

    decode_unit #(.XLEN(64), .NREGS(32), .SB_ENABLE(1'b1)) u_dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r64_in_ready),
        .in_instr(in_instr), .in_pc({32'b0, in_pc}), .out_valid(r64_valid),
        .out_ready(out_ready), .out_pc(r64_pc), .out_rs1(r64_rs1), .out_rs2(r64_rs2),
        .out_rd(r64_rd), .out_imm(r64_imm), .out_opcode(r64_opcode),
        .out_funct3(r64_funct3), .out_funct7(r64_funct7), .out_use_rs1(r64_use_rs1),
        .out_use_rs2(r64_use_rs2), .out_we_rd(r64_we_rd), .out_illegal(r64_illegal),
        .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd)
    );

    decode_unit #(.XLEN(32), .NREGS(16), .SB_ENABLE(1'b1)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r16_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(r16_valid), .out_ready(out_ready),
        .out_pc(r16_pc), .out_rs1(r16_rs1), .out_rs2(r16_rs2), .out_rd(r16_rd),
        .out_imm(r16_imm), .out_opcode(r16_opcode), .out_funct3(r16_funct3),
        .out_funct7(r16_funct7), .out_use_rs1(r16_use_rs1), .out_use_rs2(r16_use_rs2),
        .out_we_rd(r16_we_rd), .out_illegal(r16_illegal), .flush(flush),
        .wb_valid(wb_valid), .wb_rd(wb_rd)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        out_ready = 1'b1; flush = 1'b0; wb_valid = 1'b0; wb_rd = '0;
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_imm", 64'(out_imm), 64'd0);
        #10 rst = 1'b0;
        tick();

        // ADDI x5,x0,-1
        in_valid = 1'b1; in_instr = 32'hFFF00293; in_pc = 32'h100;
        #1 check("addi_in_ready", 64'(in_ready), 64'd1);
        tick();
        check("addi_valid", 64'(out_valid), 64'd1);
        check("addi_rd", 64'(out_rd), 64'd5);
        check("addi_imm", 64'(out_imm), 64'hFFFF_FFFF);
        check("addi_we", 64'(out_we_rd), 64'd1);
        check("addi_pc", 64'(out_pc), 64'h100);
        check("addi_imm64", r64_imm, 64'hFFFF_FFFF_FFFF_FFFF);

        // ADD x6,x5,x1 stalls on busy x5
        in_instr = 32'h00128333; in_pc = 32'h104;
        #1 check("raw_stall", 64'(in_ready), 64'd0);
        tick();
        check("drain_valid", 64'(out_valid), 64'd0);
        check("raw_stall_hold", 64'(in_ready), 64'd0);
        wb_valid = 1'b1; wb_rd = 5'd5;
        #1 check("wb_bypass", 64'(in_ready), 64'd1);
        tick();
        wb_valid = 1'b0;
        check("add_valid", 64'(out_valid), 64'd1);
        check("add_rd", 64'(out_rd), 64'd6);
        check("add_rs1", 64'(out_rs1), 64'd5);
        check("add_rs2", 64'(out_rs2), 64'd1);
        check("add_imm", 64'(out_imm), 64'd0);

        // LUI x7 accepted while wb clears x7: set wins
        in_instr = 32'h123453B7; wb_valid = 1'b1; wb_rd = 5'd7;
        tick();
        wb_valid = 1'b0;
        check("lui_imm", 64'(out_imm), 64'h1234_5000);
        check("lui_rd", 64'(out_rd), 64'd7);
        in_instr = 32'h00038433;  // ADD x8,x7,x0
        #1 check("set_wins", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        wb_valid = 1'b1; wb_rd = 5'd6;
        tick();
        wb_rd = 5'd7;
        tick();
        wb_valid = 1'b0;

        // Hold ADDI x9 then flush it
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00100493;
        tick();
        in_valid = 1'b0;
        check("hold_valid0", 64'(out_valid), 64'd1);
        check("hold_imm", 64'(out_imm), 64'd1);
        tick();
        check("hold_valid1", 64'(out_valid), 64'd1);
        check("hold_rd", 64'(out_rd), 64'd9);
        flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00100513;
        #1 check("flush_blocks", 64'(in_ready), 64'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check("flush_kill", 64'(out_valid), 64'd0);
        in_valid = 1'b1; in_instr = 32'h000485B3;  // ADD x11,x9,x0
        #1 check("flush_clr_busy", 64'(in_ready), 64'd1);

        // BEQ x0,x0,-4 / SW x2,8(x1) / bad low bits, back-to-back
        in_instr = 32'hFE000EE3;
        tick();
        check("beq_imm", 64'(out_imm), 64'hFFFF_FFFC);
        check("beq_we", 64'(out_we_rd), 64'd0);
        check("beq_use_rs2", 64'(out_use_rs2), 64'd1);
        in_instr = 32'h0020A423;
        tick();
        check("sw_imm", 64'(out_imm), 64'd8);
        check("sw_rs2", 64'(out_rs2), 64'd2);
        check("sw_rd", 64'(out_rd), 64'd0);
        in_instr = 32'hFFF00290;
        tick();
        check("lowbits_illegal", 64'(out_illegal), 64'd1);
        check("lowbits_use_rs1", 64'(out_use_rs1), 64'd0);
        check("lowbits_we", 64'(out_we_rd), 64'd0);

        // ADDIW x1,x0,1: illegal on RV32, legal on RV64
        in_instr = 32'h0010009B;
        tick();
        in_valid = 1'b0;
        check("addiw32_illegal", 64'(out_illegal), 64'd1);
        check("addiw32_we", 64'(out_we_rd), 64'd0);
        check("addiw64_illegal", 64'(r64_illegal), 64'd0);
        check("addiw64_rd", 64'(r64_rd), 64'd1);
        check("addiw64_imm", r64_imm, 64'd1);
        in_valid = 1'b1; in_instr = 32'h00008133;  // ADD x2,x1,x0
        #1;
        check("addiw32_no_busy", 64'(in_ready), 64'd1);
        check("addiw64_busy", 64'(r64_in_ready), 64'd0);
        in_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd1;
        tick();
        wb_valid = 1'b0;

        // ADD x17,x1,x2: illegal only on RV32E
        in_valid = 1'b1; in_instr = 32'h002088B3;
        tick();
        in_valid = 1'b0;
        check("x17_e_illegal", 64'(r16_illegal), 64'd1);
        check("x17_i_illegal", 64'(out_illegal), 64'd0);
        check("x17_i_rd", 64'(out_rd), 64'd17);

        // Asynchronous reset mid-cycle
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_rd", 64'(out_rd), 64'd0);
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
